packet_buffer: RTL and testbench
================================

// Module: packet_buffer
// PURPOSE
//  Single TX packet buffer on the upstream side of the RP BFM packet sender. The test
//  writes AVST RX packets into it one per cycle, then commits the batch.
//  The buffer raises a send request with the batch size. It serves packet pairs
//  (CH0/CH1) at the index the sender drives. It clears itself on the sender's ack.
//  One instance feeds one sender buffer slot (i_packet/i_send_req/i_buf_size lane).
// PARAMETERS
//  BUF_SIZE       8                   entry count; power of two, >=2; must equal sender BUF_SIZE
//  LOG2_BUF_SIZE  $clog2(BUF_SIZE)    derived; do not override
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  asynchronous active-low reset
//  i_wr_valid  in   1                  write one packet this cycle
//  i_wr_pkt    in   t_avst_rx          packet to store (single channel)
//  i_commit    in   1                  close the batch and request send
//  o_wr_ready  out  1                  buffer accepts writes (FILL and not full)
//  o_buf_size  out  LOG2_BUF_SIZE+1    packets in the committed batch
//  o_send_req  out  1                  send request to sender
//  i_send_ack  in   1                  1-cycle ack from sender; batch fully sent
//  i_buf_idx   in   LOG2_BUF_SIZE      sender read index (even values in normal use)
//  o_packet    out  t_avst_rxs         CH0 = entry[idx], CH1 = entry[idx+1]
//  o_count     out  LOG2_BUF_SIZE+1    packets currently held
//  o_overflow  out  1                  sticky: a write was dropped
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=FILL, count=0, o_send_req=0, o_overflow=0,
//   o_buf_size=0, o_wr_ready=1. Memory contents are not reset; validity is qualified by count.
//  Storage: BUF_SIZE x t_avst_rx regs, wr_ptr = count[LOG2_BUF_SIZE-1:0].
//  FSM: FILL -> REQ -> FILL.
//   FILL: o_wr_ready = (count<BUF_SIZE). A write with ready stores at wr_ptr and does count+1
//    (visible next cycle). When i_commit=1 and (count + accepted write) > 0, go to REQ.
//    o_buf_size latches that total. A same-cycle write is included in the batch.
//    A commit with an empty batch is ignored and the FSM stays in FILL.
//   REQ: o_send_req=1 (registered; rises 1 cycle after commit), o_wr_ready=0, and
//    o_buf_size is held stable. Writes are dropped and o_overflow is set. Commit is ignored.
//    On i_send_ack: o_send_req=0 and count=0 next cycle, then return to FILL.
//   i_send_ack while in FILL is ignored.
//  Full: a write when count==BUF_SIZE is dropped and sets o_overflow. count is unchanged.
//  o_packet (combinational from i_buf_idx):
//   CH0 = entry[idx], with valid forced 0 when idx >= o_buf_size.
//   CH1 = entry[(idx+1) mod BUF_SIZE], with valid forced 0 when idx+1 >= o_buf_size. This
//   covers the odd-size tail.
//   In FILL, the qualifying bound is count instead of o_buf_size.
//  Index arithmetic: compare in LOG2_BUF_SIZE+1 bits so idx+1 == BUF_SIZE does not wrap
//   in the comparison.
//  o_overflow clears only on reset.
//  Reset mid-REQ: o_send_req drops immediately (async). The batch is discarded.
// TESTING
//  1 BUF_SIZE=8; write 4 pkts, commit -> o_send_req=1 next cycle, o_buf_size=4,
//    o_wr_ready=0; pairs at idx 0 and 2 match writes; ack -> count=0, FILL.
//  2 Write 3, commit -> o_buf_size=3. At idx=2: CH0.valid=1 and CH1.valid=0.
//  3 Write 8 (full, o_wr_ready=0); a 9th write is dropped -> o_overflow=1, count=8.
//    Commit -> o_buf_size=8. At idx=6: CH1=entry[7].
//  4 Commit with count=0 -> no o_send_req. Write+commit in the same cycle ->
//    o_buf_size=1 and o_send_req=1 next cycle.
//  5 Write during REQ -> dropped, o_overflow=1. i_send_ack in FILL -> no state change.
//  6 Assert rst_n=0 during REQ -> o_send_req=0 with no clock. After release: count=0 and
//    o_overflow=0. A new 2-packet batch then sends correctly.

Source files
------------

// File: rtl/packet_buffer.sv
// packet_buffer: single TX packet buffer feeding one sender slot.
// Packets are written one per cycle in FILL and committed as a batch. The
// buffer then raises a send request and serves CH0/CH1 pairs at the sender's
// index until the sender acks the batch.

package packet_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } t_avst_rx;

  typedef struct packed {
    t_avst_rx ch1;
    t_avst_rx ch0;
  } t_avst_rxs;
endpackage

module packet_buffer
  import packet_buffer_pkg::*;
#(
  parameter int BUF_SIZE      = 8,
  parameter int LOG2_BUF_SIZE = $clog2(BUF_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_valid,
  input  t_avst_rx                 i_wr_pkt,
  input  logic                     i_commit,
  output logic                     o_wr_ready,
  output logic [LOG2_BUF_SIZE:0]   o_buf_size,
  output logic                     o_send_req,
  input  logic                     i_send_ack,
  input  logic [LOG2_BUF_SIZE-1:0] i_buf_idx,
  output t_avst_rxs                o_packet,
  output logic [LOG2_BUF_SIZE:0]   o_count,
  output logic                     o_overflow
);

  typedef enum logic {ST_FILL, ST_REQ} state_t;

  localparam logic [LOG2_BUF_SIZE:0] FULL_COUNT = BUF_SIZE[LOG2_BUF_SIZE:0];
  localparam logic [LOG2_BUF_SIZE:0] ONE        = {{LOG2_BUF_SIZE{1'b0}}, 1'b1};
  localparam logic [LOG2_BUF_SIZE:0] ZERO       = '0;

  state_t                   state_reg;
  logic [LOG2_BUF_SIZE:0]   count_reg;
  logic [LOG2_BUF_SIZE:0]   buf_size_reg;
  logic                     send_req_reg;
  logic                     overflow_reg;

  // Storage is not reset; entry validity is qualified by the count/batch size.
  t_avst_rx                 mem [BUF_SIZE];

  logic                     wr_accept;
  logic                     wr_drop;
  logic [LOG2_BUF_SIZE-1:0] wr_ptr;
  logic [LOG2_BUF_SIZE:0]   fill_total;
  logic [LOG2_BUF_SIZE:0]   rd_bound;
  logic [LOG2_BUF_SIZE:0]   idx_ext;
  logic [LOG2_BUF_SIZE:0]   idx_plus1;

  assign o_wr_ready = (state_reg == ST_FILL) && (count_reg < FULL_COUNT);
  assign wr_accept  = i_wr_valid && o_wr_ready;
  assign wr_drop    = i_wr_valid && !o_wr_ready;
  assign wr_ptr     = count_reg[LOG2_BUF_SIZE-1:0];
  // Batch total includes a write accepted in the same cycle as the commit.
  assign fill_total = wr_accept ? (count_reg + ONE) : count_reg;

  assign o_buf_size = buf_size_reg;
  assign o_send_req = send_req_reg;
  assign o_count    = count_reg;
  assign o_overflow = overflow_reg;

  // Control FSM: FILL accumulates packets, REQ holds the batch until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_FILL;
      count_reg    <= '0;
      buf_size_reg <= '0;
      send_req_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_drop) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        ST_FILL: begin
          count_reg <= fill_total;
          if (i_commit && (fill_total != ZERO)) begin
            state_reg    <= ST_REQ;
            buf_size_reg <= fill_total;
            send_req_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_send_ack) begin
            state_reg    <= ST_FILL;
            count_reg    <= '0;
            send_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_FILL;
        end
      endcase
    end
  end

  // Packet storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= i_wr_pkt;
    end
  end

  // Pair read: comparisons use one extra bit so idx+1 == BUF_SIZE stays out of range.
  always_comb begin
    rd_bound        = (state_reg == ST_REQ) ? buf_size_reg : count_reg;
    idx_ext         = {1'b0, i_buf_idx};
    idx_plus1       = idx_ext + ONE;
    o_packet.ch0    = mem[i_buf_idx];
    o_packet.ch1    = mem[idx_plus1[LOG2_BUF_SIZE-1:0]];
    if (idx_ext >= rd_bound) begin
      o_packet.ch0.valid = 1'b0;
    end
    if (idx_plus1 >= rd_bound) begin
      o_packet.ch1.valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_buffer.sv
// Directed testbench for packet_buffer (BUF_SIZE=8).
module tb_packet_buffer;
  import packet_buffer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       i_wr_valid;
  t_avst_rx   i_wr_pkt;
  logic       i_commit;
  logic       o_wr_ready;
  logic [3:0] o_buf_size;
  logic       o_send_req;
  logic       i_send_ack;
  logic [2:0] i_buf_idx;
  t_avst_rxs  o_packet;
  logic [3:0] o_count;
  logic       o_overflow;

  int checks = 0;
  int fails  = 0;

  packet_buffer #(.BUF_SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (i_wr_valid),
    .i_wr_pkt   (i_wr_pkt),
    .i_commit   (i_commit),
    .o_wr_ready (o_wr_ready),
    .o_buf_size (o_buf_size),
    .o_send_req (o_send_req),
    .i_send_ack (i_send_ack),
    .i_buf_idx  (i_buf_idx),
    .o_packet   (o_packet),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d, input logic commit);
    i_wr_valid     = 1'b1;
    i_wr_pkt.valid = 1'b1;
    i_wr_pkt.sop   = 1'b1;
    i_wr_pkt.eop   = 1'b1;
    i_wr_pkt.data  = d;
    i_commit       = commit;
    tick();
    i_wr_valid = 1'b0;
    i_commit   = 1'b0;
    $display("write data=%h commit=%0d -> count=%0d ready=%0d req=%0d ovf=%0d",
             d, commit, o_count, o_wr_ready, o_send_req, o_overflow);
  endtask

  task automatic do_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    $display("commit -> req=%0d buf_size=%0d", o_send_req, o_buf_size);
  endtask

  task automatic do_ack();
    i_send_ack = 1'b1;
    tick();
    i_send_ack = 1'b0;
    $display("ack -> req=%0d count=%0d", o_send_req, o_count);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_wr_valid = 1'b0; i_wr_pkt = '0; i_commit = 1'b0;
    i_send_ack = 1'b0; i_buf_idx = '0;
    #23;
    rst_n = 1'b1;
    tick();
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0d exp=0", o_send_req); end
    checks++; if (o_count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%0d exp=0", o_overflow); end
    checks++; if (o_buf_size !== 4'd0) begin fails++; $display("FAIL reset_bufsize got=%0d exp=0", o_buf_size); end
    checks++; if (o_wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0d exp=1", o_wr_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) do_write(32'hA0 + i, 1'b0);
    checks++; if (o_count !== 4'd4) begin fails++; $display("FAIL basic_count got=%0d exp=4", o_count); end
    do_commit();
    checks++; if (o_send_req !== 1'b1) begin fails++; $display("FAIL basic_req got=%0d exp=1", o_send_req); end
    checks++; if (o_buf_size !== 4'd4) begin fails++; $display("FAIL basic_bufsize got=%0d exp=4", o_buf_size); end
    checks++; if (o_wr_ready !== 1'b0) begin fails++; $display("FAIL basic_ready got=%0d exp=0", o_wr_ready); end
    for (int p = 0; p < 2; p++) begin
      i_buf_idx = 3'(2 * p);
      #1;
      checks++; if (o_packet.ch0.data !== 32'hA0 + 2 * p || o_packet.ch0.valid !== 1'b1) begin
        fails++; $display("FAIL basic_ch0 idx=%0d got=%h/%0d exp=%h/1", 2*p, o_packet.ch0.data, o_packet.ch0.valid, 32'hA0 + 2*p); end
      checks++; if (o_packet.ch1.data !== 32'hA1 + 2 * p || o_packet.ch1.valid !== 1'b1) begin
        fails++; $display("FAIL basic_ch1 idx=%0d got=%h/%0d exp=%h/1", 2*p, o_packet.ch1.data, o_packet.ch1.valid, 32'hA1 + 2*p); end
    end
    do_ack();
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL basic_ack_req got=%0d exp=0", o_send_req); end
    checks++; if (o_count !== 4'd0) begin fails++; $display("FAIL basic_ack_count got=%0d exp=0", o_count); end
    checks++; if (o_wr_ready !== 1'b1) begin fails++; $display("FAIL basic_ack_ready got=%0d exp=1", o_wr_ready); end
  endtask

  task automatic test_odd();
    for (int i = 0; i < 3; i++) do_write(32'hB0 + i, 1'b0);
    do_commit();
    checks++; if (o_buf_size !== 4'd3) begin fails++; $display("FAIL odd_bufsize got=%0d exp=3", o_buf_size); end
    i_buf_idx = 3'd2;
    #1;
    checks++; if (o_packet.ch0.valid !== 1'b1 || o_packet.ch0.data !== 32'hB2) begin
      fails++; $display("FAIL odd_ch0 got=%h/%0d exp=000000b2/1", o_packet.ch0.data, o_packet.ch0.valid); end
    checks++; if (o_packet.ch1.valid !== 1'b0) begin fails++; $display("FAIL odd_ch1_valid got=%0d exp=0", o_packet.ch1.valid); end
    do_ack();
  endtask

  task automatic test_commit_edge();
    do_commit();
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL empty_commit_req got=%0d exp=0", o_send_req); end
    checks++; if (o_wr_ready !== 1'b1) begin fails++; $display("FAIL empty_commit_ready got=%0d exp=1", o_wr_ready); end
    do_write(32'hD0, 1'b1);
    checks++; if (o_send_req !== 1'b1) begin fails++; $display("FAIL wrcommit_req got=%0d exp=1", o_send_req); end
    checks++; if (o_buf_size !== 4'd1) begin fails++; $display("FAIL wrcommit_bufsize got=%0d exp=1", o_buf_size); end
    i_buf_idx = 3'd0;
    #1;
    checks++; if (o_packet.ch0.valid !== 1'b1 || o_packet.ch0.data !== 32'hD0) begin
      fails++; $display("FAIL wrcommit_ch0 got=%h/%0d exp=000000d0/1", o_packet.ch0.data, o_packet.ch0.valid); end
    checks++; if (o_packet.ch1.valid !== 1'b0) begin fails++; $display("FAIL wrcommit_ch1_valid got=%0d exp=0", o_packet.ch1.valid); end
    do_ack();
  endtask

  task automatic test_req_drop();
    do_write(32'hE0, 1'b0);
    do_write(32'hE1, 1'b0);
    do_commit();
    checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL req_ovf_before got=%0d exp=0", o_overflow); end
    do_write(32'hEE, 1'b0);
    checks++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL req_ovf got=%0d exp=1", o_overflow); end
    checks++; if (o_count !== 4'd2) begin fails++; $display("FAIL req_count got=%0d exp=2", o_count); end
    checks++; if (o_buf_size !== 4'd2) begin fails++; $display("FAIL req_bufsize got=%0d exp=2", o_buf_size); end
    do_ack();
    do_write(32'hE5, 1'b0);
    do_ack();
    checks++; if (o_count !== 4'd1) begin fails++; $display("FAIL fill_ack_count got=%0d exp=1", o_count); end
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL fill_ack_req got=%0d exp=0", o_send_req); end
    checks++; if (o_wr_ready !== 1'b1) begin fails++; $display("FAIL fill_ack_ready got=%0d exp=1", o_wr_ready); end
  endtask

  task automatic test_async_reset();
    do_write(32'hF8, 1'b0);
    do_commit();
    checks++; if (o_send_req !== 1'b1) begin fails++; $display("FAIL arst_req_pre got=%0d exp=1", o_send_req); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted -> req=%0d count=%0d", o_send_req, o_count);
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL arst_req got=%0d exp=0", o_send_req); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (o_count !== 4'd0) begin fails++; $display("FAIL arst_count got=%0d exp=0", o_count); end
    checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL arst_ovf got=%0d exp=0", o_overflow); end
    do_write(32'hF0, 1'b0);
    do_write(32'hF1, 1'b0);
    do_commit();
    checks++; if (o_send_req !== 1'b1 || o_buf_size !== 4'd2) begin
      fails++; $display("FAIL arst_batch req/size got=%0d/%0d exp=1/2", o_send_req, o_buf_size); end
    i_buf_idx = 3'd0;
    #1;
    checks++; if (o_packet.ch0.data !== 32'hF0 || o_packet.ch1.data !== 32'hF1 ||
                  o_packet.ch0.valid !== 1'b1 || o_packet.ch1.valid !== 1'b1) begin
      fails++; $display("FAIL arst_pair got=%h/%0d %h/%0d exp=000000f0/1 000000f1/1",
                        o_packet.ch0.data, o_packet.ch0.valid, o_packet.ch1.data, o_packet.ch1.valid); end
    do_ack();
    checks++; if (o_send_req !== 1'b0) begin fails++; $display("FAIL arst_ack_req got=%0d exp=0", o_send_req); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) do_write(32'hC0 + i, 1'b0);
    checks++; if (o_wr_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%0d exp=0", o_wr_ready); end
    checks++; if (o_count !== 4'd8) begin fails++; $display("FAIL full_count got=%0d exp=8", o_count); end
    checks++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL full_ovf_before got=%0d exp=0", o_overflow); end
    do_write(32'hCC, 1'b0);
    checks++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL full_ovf got=%0d exp=1", o_overflow); end
    checks++; if (o_count !== 4'd8) begin fails++; $display("FAIL full_count_after got=%0d exp=8", o_count); end
    do_commit();
    checks++; if (o_buf_size !== 4'd8) begin fails++; $display("FAIL full_bufsize got=%0d exp=8", o_buf_size); end
    i_buf_idx = 3'd6;
    #1;
    checks++; if (o_packet.ch1.data !== 32'hC7 || o_packet.ch1.valid !== 1'b1) begin
      fails++; $display("FAIL full_ch1_idx6 got=%h/%0d exp=000000c7/1", o_packet.ch1.data, o_packet.ch1.valid); end
    checks++; if (o_packet.ch0.data !== 32'hC6) begin fails++; $display("FAIL full_ch0_idx6 got=%h exp=000000c6", o_packet.ch0.data); end
    i_buf_idx = 3'd7;
    #1;
    checks++; if (o_packet.ch0.valid !== 1'b1 || o_packet.ch1.valid !== 1'b0) begin
      fails++; $display("FAIL full_idx7_valid got=%0d/%0d exp=1/0", o_packet.ch0.valid, o_packet.ch1.valid); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_commit_edge();
    test_req_drop();
    test_async_reset();
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
